mem_wb_writer: RTL and testbench



---
 rtl/mem_wb_writer_pkg.sv | 25 ++
 rtl/mem_timeout_counter.sv | 43 ++++
 rtl/mem_wb_writer.sv | 161 ++++++++++++++++
 tb/tb_mem_wb_writer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_writer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_writer_pkg
// Description : Shared constants and helpers for the MEM/WB writeback block.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_wb_writer_pkg;

    localparam int DATA_W          = 32;
    localparam int REG_AW          = 5;
    localparam int TIMEOUT_DEFAULT = 16;

    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_REQ  = 1'b1;

    // $0 is hardwired to zero, so a write to it must never reach the file.
    function automatic logic reg_write_en(input logic regwrite,
                                          input logic [REG_AW-1:0] dest);
        return regwrite && (dest != REG_ZERO);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_timeout_counter.sv
`default_nettype none
// ============================================================================
// Module      : mem_timeout_counter
// Description : Wait-cycle counter with clear, enable and terminal count.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_timeout_counter #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o,
    output logic             tc_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign tc_o    = (count_q == CNT_W'(TIMEOUT - 1));

endmodule
`default_nettype wire

// File: rtl/mem_wb_writer.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_writer
// Description : MEM/WB stage: data-memory req/ack handshake with timeout,
//               upstream stall, and register-file write port drive.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wb_writer
    import mem_wb_writer_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int CNT_W   = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                EXMEM_RegWrite_out,
    input  logic                EXMEM_MemtoReg_out,
    input  logic                EXMEM_MemRead_out,
    input  logic                EXMEM_MemWrite_out,
    input  logic [REG_AW-1:0]   EXMEM_destination_out,
    input  logic [DATA_W-1:0]   EXMEM_ALUresult_out,
    input  logic [DATA_W-1:0]   EXMEM_SWDATA_out,
    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                stall_out,
    output logic                mem_err,
    output logic                MEMWB_RegWrite_out,
    output logic [REG_AW-1:0]   MEMWB_destination_out,
    output logic [DATA_W-1:0]   WBID_mux_out
);

    logic [0:0]        state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              err_q, err_d;
    logic              wr_q, wr_d;
    logic [REG_AW-1:0] dest_q, dest_d;
    logic [DATA_W-1:0] data_q, data_d;

    logic              memop;
    logic              cnt_tc;
    logic              cnt_clr;
    logic [CNT_W-1:0]  cnt_val;

    assign memop = EXMEM_MemRead_out | EXMEM_MemWrite_out;

    // Counter only runs while waiting; any exit from REQ rezeroes it.
    assign cnt_clr = (state_q == ST_IDLE) || mem_ack || cnt_tc;

    mem_timeout_counter #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (cnt_clr),
        .en_i    (1'b1),
        .count_o (cnt_val),
        .tc_o    (cnt_tc)
    );

    always_comb begin
        stall_out = 1'b0;
        if (state_q == ST_IDLE) begin
            stall_out = memop;
        end else begin
            stall_out = !mem_ack;
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = 1'b0;
        wr_d    = 1'b0;
        dest_d  = dest_q;
        data_d  = data_q;
        case (state_q)
            ST_IDLE: begin
                if (memop) begin
                    state_d = ST_REQ;
                    req_d   = 1'b1;
                    we_d    = EXMEM_MemWrite_out;
                    addr_d  = EXMEM_ALUresult_out;
                    wdata_d = EXMEM_SWDATA_out;
                end else begin
                    wr_d   = reg_write_en(EXMEM_RegWrite_out, EXMEM_destination_out);
                    dest_d = EXMEM_destination_out;
                    data_d = EXMEM_ALUresult_out;
                end
            end
            ST_REQ: begin
                // An ack on the terminal cycle still completes the access.
                if (mem_ack) begin
                    state_d = ST_IDLE;
                    req_d   = 1'b0;
                    if (!we_q) begin
                        wr_d   = reg_write_en(EXMEM_RegWrite_out, EXMEM_destination_out);
                        dest_d = EXMEM_destination_out;
                        data_d = EXMEM_MemtoReg_out ? mem_rdata : EXMEM_ALUresult_out;
                    end
                end else if (cnt_tc) begin
                    state_d = ST_IDLE;
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            wr_q    <= 1'b0;
            dest_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            wr_q    <= wr_d;
            dest_q  <= dest_d;
            data_q  <= data_d;
        end
    end

    assign mem_req               = req_q;
    assign mem_we                = we_q;
    assign mem_addr              = addr_q;
    assign mem_wdata             = wdata_q;
    assign mem_err               = err_q;
    assign MEMWB_RegWrite_out    = wr_q;
    assign MEMWB_destination_out = dest_q;
    assign WBID_mux_out          = data_q;

    logic unused_cnt;
    assign unused_cnt = ^cnt_val;

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_wb_writer
// Description : Directed self-checking bench for mem_wb_writer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_wb_writer;

    logic        clk;
    logic        rst;
    logic        RegWrite, MemtoReg, MemRead, MemWrite;
    logic [4:0]  dest;
    logic [31:0] alu, swdata;
    logic        mem_req, mem_we, mem_ack, stall_out, mem_err;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        wb_we;
    logic [4:0]  wb_dest;
    logic [31:0] wb_data;

    int passed = 0;
    int total  = 0;

    mem_wb_writer #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .EXMEM_RegWrite_out    (RegWrite),
        .EXMEM_MemtoReg_out    (MemtoReg),
        .EXMEM_MemRead_out     (MemRead),
        .EXMEM_MemWrite_out    (MemWrite),
        .EXMEM_destination_out (dest),
        .EXMEM_ALUresult_out   (alu),
        .EXMEM_SWDATA_out      (swdata),
        .mem_req               (mem_req),
        .mem_we                (mem_we),
        .mem_addr              (mem_addr),
        .mem_wdata             (mem_wdata),
        .mem_ack               (mem_ack),
        .mem_rdata             (mem_rdata),
        .stall_out             (stall_out),
        .mem_err               (mem_err),
        .MEMWB_RegWrite_out    (wb_we),
        .MEMWB_destination_out (wb_dest),
        .WBID_mux_out          (wb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        RegWrite = 0; MemtoReg = 0; MemRead = 0; MemWrite = 0;
        dest = 5'd0; alu = 32'd0; swdata = 32'd0; mem_ack = 0; mem_rdata = 32'd0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        #12;
        total++; if ({mem_req, mem_we, mem_err, wb_we} !== 4'b0000) $display("FAIL rst_ctrl: got %b want 0000", {mem_req, mem_we, mem_err, wb_we}); else passed++;
        total++; if ({mem_addr, mem_wdata, wb_data, wb_dest} !== 101'd0) $display("FAIL rst_data: got %h/%h/%h/%h want 0", mem_addr, mem_wdata, wb_data, wb_dest); else passed++;
        total++; if (stall_out !== 1'b0) $display("FAIL rst_stall: got %b want 0", stall_out); else passed++;
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    task automatic test_alu();
        RegWrite = 1; dest = 5'd8; alu = 32'h0000000A;
        #1;
        total++; if (stall_out !== 1'b0) $display("FAIL alu_stall: got %b want 0", stall_out); else passed++;
        tick();
        RegWrite = 0; dest = 5'd3; alu = 32'h77;
        total++; if (wb_we !== 1'b1) $display("FAIL alu_we: got %b want 1", wb_we); else passed++;
        total++; if (wb_dest !== 5'd8) $display("FAIL alu_dest: got %0d want 8", wb_dest); else passed++;
        total++; if (wb_data !== 32'h0000000A) $display("FAIL alu_data: got %h want 0000000a", wb_data); else passed++;
        tick();
        total++; if (wb_we !== 1'b0) $display("FAIL alu_we_off: got %b want 0", wb_we); else passed++;
        idle_inputs();
        tick();
    endtask

    task automatic test_load();
        int bad_stall = 0;
        MemRead = 1; MemtoReg = 1; RegWrite = 1; dest = 5'd9; alu = 32'h40;
        #1;
        total++; if (stall_out !== 1'b1) $display("FAIL ld_stall_idle: got %b want 1", stall_out); else passed++;
        tick();
        total++; if ({mem_req, mem_we} !== 2'b10) $display("FAIL ld_req_we: got %b want 10", {mem_req, mem_we}); else passed++;
        total++; if (mem_addr !== 32'h40) $display("FAIL ld_addr: got %h want 00000040", mem_addr); else passed++;
        for (int i = 0; i < 2; i++) begin
            #1;
            if (stall_out !== 1'b1 || wb_we !== 1'b0) bad_stall++;
            tick();
        end
        total++; if (bad_stall != 0) $display("FAIL ld_wait: got %0d bad cycles want 0", bad_stall); else passed++;
        mem_ack = 1; mem_rdata = 32'hDEADBEEF;
        #1;
        total++; if (stall_out !== 1'b0) $display("FAIL ld_stall_ack: got %b want 0", stall_out); else passed++;
        tick();
        idle_inputs();
        total++; if ({mem_req, wb_we} !== 2'b01) $display("FAIL ld_wb_we: got %b want 01", {mem_req, wb_we}); else passed++;
        total++; if (wb_data !== 32'hDEADBEEF) $display("FAIL ld_wb_data: got %h want deadbeef", wb_data); else passed++;
        total++; if (wb_dest !== 5'd9) $display("FAIL ld_wb_dest: got %0d want 9", wb_dest); else passed++;
        tick();
        total++; if (wb_we !== 1'b0) $display("FAIL ld_pulse: got %b want 0", wb_we); else passed++;
    endtask

    task automatic test_store();
        MemWrite = 1; RegWrite = 1; dest = 5'd5; alu = 32'h10; swdata = 32'h55;
        tick();
        total++; if ({mem_req, mem_we} !== 2'b11) $display("FAIL st_req_we: got %b want 11", {mem_req, mem_we}); else passed++;
        total++; if (mem_wdata !== 32'h55 || mem_addr !== 32'h10) $display("FAIL st_addr_data: got %h/%h want 00000010/00000055", mem_addr, mem_wdata); else passed++;
        mem_ack = 1;
        #1;
        total++; if (stall_out !== 1'b0) $display("FAIL st_stall_ack: got %b want 0", stall_out); else passed++;
        tick();
        idle_inputs();
        total++; if ({mem_req, wb_we} !== 2'b00) $display("FAIL st_done: got %b want 00", {mem_req, wb_we}); else passed++;
        tick();
        total++; if (wb_we !== 1'b0) $display("FAIL st_no_wr: got %b want 0", wb_we); else passed++;
    endtask

    task automatic test_timeout();
        int req_cycles = 1;
        int bad = 0;
        bit dropped = 0;
        MemRead = 1; MemtoReg = 1; RegWrite = 1; dest = 5'd7; alu = 32'h80;
        tick();
        for (int i = 0; i < 40; i++) begin
            if (stall_out !== 1'b1 || wb_we !== 1'b0 || mem_err !== 1'b0) bad++;
            tick();
            if (mem_req === 1'b0) begin
                dropped = 1;
                break;
            end
            req_cycles++;
        end
        total++; if (!dropped) $display("FAIL to_drop: got req still high want drop within 40 cycles"); else passed++;
        total++; if (req_cycles != 16) $display("FAIL to_cycles: got %0d want 16", req_cycles); else passed++;
        total++; if (bad != 0) $display("FAIL to_wait: got %0d bad cycles want 0", bad); else passed++;
        total++; if ({mem_err, wb_we} !== 2'b10) $display("FAIL to_err: got %b want 10", {mem_err, wb_we}); else passed++;
        idle_inputs();
        #1;
        total++; if (stall_out !== 1'b0) $display("FAIL to_release: got %b want 0", stall_out); else passed++;
        tick();
        total++; if ({mem_err, mem_req, wb_we} !== 3'b000) $display("FAIL to_err_pulse: got %b want 000", {mem_err, mem_req, wb_we}); else passed++;
    endtask

    task automatic test_zero_dest();
        RegWrite = 1; dest = 5'd0; alu = 32'h1234;
        tick();
        total++; if (wb_we !== 1'b0 || wb_data !== 32'h1234) $display("FAIL z_alu: got we=%b data=%h want we=0 data=00001234", wb_we, wb_data); else passed++;
        MemRead = 1; MemtoReg = 1; alu = 32'h44;
        tick();
        mem_ack = 1; mem_rdata = 32'hCAFEF00D;
        tick();
        idle_inputs();
        total++; if (wb_we !== 1'b0 || wb_data !== 32'hCAFEF00D) $display("FAIL z_load: got we=%b data=%h want we=0 data=cafef00d", wb_we, wb_data); else passed++;
        tick();
    endtask

    task automatic test_back_to_back();
        MemRead = 1; MemtoReg = 1; RegWrite = 1; dest = 5'd12; alu = 32'h100;
        tick();
        mem_ack = 1; mem_rdata = 32'h0BADF00D;
        tick();
        mem_ack = 0; MemRead = 0; MemtoReg = 0; RegWrite = 0; MemWrite = 1; alu = 32'h200; swdata = 32'h99;
        #1;
        total++; if ({wb_we, mem_req, stall_out} !== 3'b101) $display("FAIL b2b_gap: got %b want 101", {wb_we, mem_req, stall_out}); else passed++;
        tick();
        total++; if ({mem_req, mem_we, wb_we} !== 3'b110 || mem_addr !== 32'h200) $display("FAIL b2b_reenter: got %b addr=%h want 110 addr=00000200", {mem_req, mem_we, wb_we}, mem_addr); else passed++;
        mem_ack = 1;
        tick();
        idle_inputs();
        mem_ack = 1; mem_rdata = 32'hFFFFFFFF;
        tick();
        total++; if ({mem_req, wb_we, stall_out} !== 3'b000) $display("FAIL idle_ack: got %b want 000", {mem_req, wb_we, stall_out}); else passed++;
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid();
        MemRead = 1; MemtoReg = 1; RegWrite = 1; dest = 5'd4; alu = 32'h300;
        tick();
        tick();
        total++; if (mem_req !== 1'b1) $display("FAIL rm_pre: got %b want 1", mem_req); else passed++;
        rst = 1'b0;
        #1;
        total++; if ({mem_req, mem_we, mem_err, wb_we} !== 4'b0000 || mem_addr !== 32'd0) $display("FAIL rm_async: got %b addr=%h want 0000 addr=0", {mem_req, mem_we, mem_err, wb_we}, mem_addr); else passed++;
        tick();
        rst = 1'b1;
        idle_inputs();
        mem_ack = 1; mem_rdata = 32'h11111111;
        tick();
        total++; if ({mem_req, wb_we, stall_out} !== 3'b000) $display("FAIL rm_after: got %b want 000", {mem_req, wb_we, stall_out}); else passed++;
        idle_inputs();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_timeout();
        test_zero_dest();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
